// File: rtl/associative_data_array_requester_pkg.sv
// -----------------------------------------------------------------------------
// associative_data_array_requester_pkg
//   Shared definitions for the data-array requester and its response FIFO:
//   controller state encoding, default array geometry and a width helper for
//   occupancy counters.
// -----------------------------------------------------------------------------
package associative_data_array_requester_pkg;

  // Controller states: RST holds everything quiet for one cycle, INIT zeroes
  // the array, RUN serves requests, DRAIN waits out reads before a re-init.
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Default array geometry.
  localparam int DEFAULT_ELEMENT_BITS = 64;
  localparam int DEFAULT_NUMBER_SETS  = 64;
  localparam int DEFAULT_NUMBER_WAYS  = 16;
  localparam int DEFAULT_SET_PTR_BITS = $clog2(DEFAULT_NUMBER_SETS);
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  // Width of a counter that must hold every value from 0 to max_value.
  function automatic int count_width(input int max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/associative_data_array_resp_fifo.sv
// -----------------------------------------------------------------------------
// associative_data_array_resp_fifo
//   Synchronous FIFO holding read data returned by the data array until the
//   consumer takes it. A pop and a push in the same cycle are legal when full
//   (the freed slot is refilled) and when empty (the pop is ignored and the
//   push still lands).
//
// Ports:
//   clk_in        clock
//   reset_n_in    asynchronous active-low reset, empties the FIFO
//   push_in       write push_data_in at the tail
//   push_data_in  data to push
//   pop_in        remove the head entry
//   pop_data_out  current head entry (meaningful when count_out != 0)
//   count_out     number of stored entries
// -----------------------------------------------------------------------------
module associative_data_array_resp_fifo
  import associative_data_array_requester_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ELEMENT_BITS,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] pop_data_out,
  output logic [CNT_W-1:0] count_out
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop_in & ~w_empty;
  assign w_do_push = push_in & (~w_full | w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: clocked state uses <= so every register samples pre-edge values;
      // a blocking = here would let later statements see the updated value.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was pushed, so clearing it would only add reset fan-out.
  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data_in;
  end

  assign pop_data_out = r_mem[r_rd_ptr];
  assign count_out    = r_count;

endmodule

// File: rtl/associative_data_array_requester.sv
// -----------------------------------------------------------------------------
// associative_data_array_requester
//   Initiator-side controller for the set-associative data array. After reset
//   (or on init_start_in) it writes zero to every way of every set, one set
//   per cycle. In normal operation it forwards read/write requests to the
//   array and queues the one-cycle-latency read data in a response FIFO that
//   is returned in request order. Read acceptance is credit limited so the
//   FIFO can never overflow.
//
// Ports:
//   clk_in, reset_n_in          clock, asynchronous active-low reset
//   req_*                       request channel (valid/ready), write or read
//   resp_*                      read response channel (valid/ready)
//   init_start_in               pulse: drain outstanding reads, re-initialise
//   init_done_out               array initialised, serving requests
//   array_*_out                 command ports to the data array
//   array_read_element_in       array read data, valid the cycle after access
// -----------------------------------------------------------------------------
module associative_data_array_requester
  import associative_data_array_requester_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEFAULT_ELEMENT_BITS,
  parameter int NUMBER_SETS                 = DEFAULT_NUMBER_SETS,
  parameter int NUMBER_WAYS                 = DEFAULT_NUMBER_WAYS,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
  parameter int RESP_FIFO_DEPTH             = DEFAULT_FIFO_DEPTH
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n_in,
  // request channel
  input  logic                                   req_valid_in,
  output logic                                   req_ready_out,
  input  logic                                   req_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       req_set_addr_in,
  input  logic [NUMBER_WAYS-1:0]                 req_way_select_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_write_data_in,
  // response channel
  output logic                                   resp_valid_out,
  input  logic                                   resp_ready_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp_data_out,
  // initialisation control
  input  logic                                   init_start_in,
  output logic                                   init_done_out,
  // data array interface
  output logic                                   array_access_en_out,
  output logic                                   array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       array_set_addr_out,
  output logic [NUMBER_WAYS-1:0]                 array_way_select_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] array_write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] array_read_element_in
);

  localparam int CNT_W = count_width(RESP_FIFO_DEPTH);

  state_t                           r_state;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] r_init_set;
  logic [CNT_W-1:0]                 r_outstanding;  // in-flight read + FIFO entries
  logic                             r_rd_inflight;  // array data is valid this cycle

  logic                                   w_credit_ok;
  logic                                   w_accept;
  logic                                   w_rd_accept;
  logic                                   w_resp_hs;
  logic [CNT_W-1:0]                       w_fifo_count;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] w_fifo_data;

  // Writes never need a credit; reads need a free slot counting the read that
  // is still in flight to the array.
  assign w_credit_ok   = (r_outstanding < CNT_W'(RESP_FIFO_DEPTH));
  assign req_ready_out = (r_state == ST_RUN) & (req_write_in | w_credit_ok);
  assign w_accept      = req_valid_in & req_ready_out;
  assign w_rd_accept   = w_accept & ~req_write_in;
  assign w_resp_hs     = resp_valid_out & resp_ready_in;

  assign init_done_out  = (r_state == ST_RUN);
  assign resp_valid_out = (w_fifo_count != '0);
  // The FIFO storage is not reset, so keep the data bus quiet when idle.
  assign resp_data_out  = resp_valid_out ? w_fifo_data : '0;

  // Array command mux: INIT sweeps the sets, RUN passes the request through.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    array_access_en_out     = 1'b0;
    array_write_en_out      = 1'b0;
    array_set_addr_out      = '0;
    array_way_select_out    = '0;
    array_write_element_out = '0;
    case (r_state)
      ST_INIT: begin
        array_access_en_out  = 1'b1;
        array_write_en_out   = 1'b1;
        array_set_addr_out   = r_init_set;
        array_way_select_out = '1;
      end
      ST_RUN: begin
        array_access_en_out     = w_accept;
        array_write_en_out      = w_accept & req_write_in;
        array_set_addr_out      = req_set_addr_in;
        array_way_select_out    = req_way_select_in;
        array_write_element_out = req_write_data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state       <= ST_RST;
      r_init_set    <= '0;
      r_outstanding <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= w_rd_accept;

      case ({w_rd_accept, w_resp_hs})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        ST_RST: begin
          r_init_set <= '0;
          r_state    <= ST_INIT;
        end
        ST_INIT: begin
          r_init_set <= r_init_set + 1'b1;
          if (r_init_set == SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1)) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // A request presented alongside init_start_in is still accepted.
          if (init_start_in) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_outstanding == '0) begin
            r_init_set <= '0;
            r_state    <= ST_INIT;
          end
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

  // Read data is captured in the cycle after the access, before any write
  // issued in that same cycle can change the array contents.
  associative_data_array_resp_fifo #(
    .WIDTH (SINGLE_ELEMENT_SIZE_IN_BITS),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .push_in      (r_rd_inflight),
    .push_data_in (array_read_element_in),
    .pop_in       (w_resp_hs),
    .pop_data_out (w_fifo_data),
    .count_out    (w_fifo_count)
  );

endmodule

// File: tb/tb_associative_data_array_requester.sv
// -----------------------------------------------------------------------------
// tb_associative_data_array_requester
//   Directed bench with a behavioural data array (one-cycle read latency) and
//   a response scoreboard: expected read data is queued when a read is
//   accepted and compared by an independent monitor on each response
//   handshake.
// -----------------------------------------------------------------------------
module tb_associative_data_array_requester;

  localparam int EW = 64;
  localparam int NS = 64;
  localparam int NW = 16;
  localparam int SW = 6;
  localparam int FD = 4;

  logic          clk_in = 1'b0;
  logic          reset_n_in;
  logic          req_valid_in;
  logic          req_ready_out;
  logic          req_write_in;
  logic [SW-1:0] req_set_addr_in;
  logic [NW-1:0] req_way_select_in;
  logic [EW-1:0] req_write_data_in;
  logic          resp_valid_out;
  logic          resp_ready_in;
  logic [EW-1:0] resp_data_out;
  logic          init_start_in;
  logic          init_done_out;
  logic          array_access_en_out;
  logic          array_write_en_out;
  logic [SW-1:0] array_set_addr_out;
  logic [NW-1:0] array_way_select_out;
  logic [EW-1:0] array_write_element_out;
  logic [EW-1:0] array_read_element_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  associative_data_array_requester #(
    .SINGLE_ELEMENT_SIZE_IN_BITS (EW),
    .NUMBER_SETS                 (NS),
    .NUMBER_WAYS                 (NW),
    .SET_PTR_WIDTH_IN_BITS       (SW),
    .RESP_FIFO_DEPTH             (FD)
  ) dut (
    .clk_in                  (clk_in),
    .reset_n_in              (reset_n_in),
    .req_valid_in            (req_valid_in),
    .req_ready_out           (req_ready_out),
    .req_write_in            (req_write_in),
    .req_set_addr_in         (req_set_addr_in),
    .req_way_select_in       (req_way_select_in),
    .req_write_data_in       (req_write_data_in),
    .resp_valid_out          (resp_valid_out),
    .resp_ready_in           (resp_ready_in),
    .resp_data_out           (resp_data_out),
    .init_start_in           (init_start_in),
    .init_done_out           (init_done_out),
    .array_access_en_out     (array_access_en_out),
    .array_write_en_out      (array_write_en_out),
    .array_set_addr_out      (array_set_addr_out),
    .array_way_select_out    (array_way_select_out),
    .array_write_element_out (array_write_element_out),
    .array_read_element_in   (array_read_element_in)
  );

  // Behavioural data array: masked write, one-cycle registered read,
  // no selected way reads as zero.
  logic [EW-1:0] mem [NS][NW];
  always @(posedge clk_in) begin
    logic [EW-1:0] rd;
    if (array_access_en_out) begin
      if (array_write_en_out) begin
        for (int w = 0; w < NW; w++)
          if (array_way_select_out[w]) mem[array_set_addr_out][w] <= array_write_element_out;
      end else begin
        rd = '0;
        for (int w = 0; w < NW; w++)
          if (array_way_select_out[w]) rd = rd | mem[array_set_addr_out][w];
        array_read_element_in <= rd;
      end
    end
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk_in) begin
    if (reset_n_in && resp_valid_out && resp_ready_in) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got %h with no read pending", resp_data_out);
      end else begin
        check("resp_data", resp_data_out, exp_q.pop_front());
      end
    end
  end

  task automatic align();
    @(posedge clk_in);
    #1;
  endtask

  // Present one request, wait (bounded) for ready, return wait cycles and
  // the cycle count right after the accepting edge.
  task automatic send(input logic wr, input int set, input logic [NW-1:0] way,
                      input logic [EW-1:0] data, input logic [EW-1:0] exp,
                      output int waits, output int acc_cyc);
    int n = 0;
    req_valid_in      = 1'b1;
    req_write_in      = wr;
    req_set_addr_in   = SW'(set);
    req_way_select_in = way;
    req_write_data_in = data;
    @(negedge clk_in);
    while (!req_ready_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 100) check("send_timeout", EW'(n), '0);
    if (!wr) exp_q.push_back(exp);
    align();
    req_valid_in = 1'b0;
    waits   = n;
    acc_cyc = cyc;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", EW'(exp_q.size()), '0);
    align();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"},
          EW'({req_ready_out, resp_valid_out, init_done_out, array_access_en_out,
               array_write_en_out, array_set_addr_out, array_way_select_out}), '0);
    check({name, "_resp_data"}, resp_data_out, '0);
    check({name, "_wr_data"}, array_write_element_out, '0);
  endtask

  // Verify one full initialisation sweep, optionally preceded by the RST cycle.
  task automatic check_init(input bit with_rst);
    int n = 0;
    @(negedge clk_in);
    if (with_rst) begin
      check("rst_cycle", EW'({array_access_en_out, req_ready_out, init_done_out}), '0);
      @(negedge clk_in);
    end else begin
      while (!array_access_en_out && n < 50) begin
        @(negedge clk_in);
        n++;
      end
    end
    for (int i = 0; i < NS; i++) begin
      check("init_ctl",
            EW'({array_access_en_out, array_write_en_out, req_ready_out, init_done_out,
                 array_set_addr_out, array_way_select_out}),
            EW'({4'b1100, SW'(i), 16'hFFFF}));
      check("init_data", array_write_element_out, '0);
      @(negedge clk_in);
    end
    check("init_done", EW'({init_done_out, req_ready_out}), EW'(2'b11));
    align();
  endtask

  initial begin
    int w, a, a2, wsum;
    reset_n_in        = 1'b0;
    req_valid_in      = 1'b0;
    req_write_in      = 1'b0;
    req_set_addr_in   = '0;
    req_way_select_in = '0;
    req_write_data_in = '0;
    resp_ready_in     = 1'b1;
    init_start_in     = 1'b0;

    // 1: reset values, RST cycle, 64-cycle init sweep.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    align();
    reset_n_in = 1'b1;
    check_init(1'b1);

    // 2: write then read back, response two cycles after acceptance.
    send(1'b1, 5, 16'h0008, 64'hDEAD_BEEF_0000_0001, '0, w, a);
    send(1'b0, 5, 16'h0008, '0, 64'hDEAD_BEEF_0000_0001, w, a);
    @(negedge clk_in);
    check("lat_n1_valid", EW'(resp_valid_out), '0);
    @(negedge clk_in);
    check("lat_n2_valid", EW'(resp_valid_out), 64'd1);
    check("lat_cycles", EW'(cyc - a), 64'd1);
    align();
    wait_drain();

    // Read followed by a write to the same element: read sees the old value.
    send(1'b0, 5, 16'h0008, '0, 64'hDEAD_BEEF_0000_0001, w, a);
    send(1'b1, 5, 16'h0008, 64'hCAFE_0000_0000_0002, '0, w, a);
    send(1'b0, 5, 16'h0008, '0, 64'hCAFE_0000_0000_0002, w, a);
    send(1'b0, 5, 16'h0000, '0, 64'h0, w, a);  // no way selected
    wait_drain();

    // 3: back-to-back reads of sets 0..7 way 0.
    for (int s = 0; s < 8; s++) send(1'b1, s, 16'h0001, 64'h1000 + EW'(s), '0, w, a);
    wsum = 0;
    send(1'b0, 0, 16'h0001, '0, 64'h1000, w, a);
    for (int s = 1; s < 8; s++) begin
      send(1'b0, s, 16'h0001, '0, 64'h1000 + EW'(s), w, a2);
      wsum += w;
    end
    check("b2b_waits", EW'(wsum), '0);
    check("b2b_span", EW'(a2 - a), 64'd7);
    wait_drain();

    // 4: credit limit with the consumer stalled.
    resp_ready_in = 1'b0;
    wsum = 0;
    for (int s = 0; s < 4; s++) begin
      send(1'b0, s, 16'h0001, '0, 64'h1000 + EW'(s), w, a);
      wsum += w;
    end
    check("credit_4_waits", EW'(wsum), '0);
    req_valid_in = 1'b1; req_write_in = 1'b0;
    req_set_addr_in = SW'(4); req_way_select_in = 16'h0001;
    @(negedge clk_in);
    check("credit_rd_blocked", EW'(req_ready_out), '0);
    align();
    @(negedge clk_in);
    check("credit_rd_blocked2", EW'(req_ready_out), '0);
    check("credit_resp_valid", EW'(resp_valid_out), 64'd1);
    req_valid_in = 1'b0;
    align();
    send(1'b1, 9, 16'h0002, 64'h9999, '0, w, a);
    check("credit_wr_waits", EW'(w), '0);
    resp_ready_in = 1'b1;
    send(1'b0, 4, 16'h0001, '0, 64'h1004, w, a);
    send(1'b0, 9, 16'h0002, '0, 64'h9999, w, a);
    wait_drain();

    // 5: re-init with two reads pending; second read rides with init_start.
    resp_ready_in = 1'b0;
    send(1'b0, 1, 16'h0001, '0, 64'h1001, w, a);
    req_valid_in = 1'b1; req_write_in = 1'b0;
    req_set_addr_in = SW'(5); req_way_select_in = 16'h0008;
    init_start_in = 1'b1;
    @(negedge clk_in);
    check("init_start_accept", EW'(req_ready_out), 64'd1);
    exp_q.push_back(64'hCAFE_0000_0000_0002);
    align();
    init_start_in = 1'b0;
    req_write_in = 1'b1; req_set_addr_in = SW'(2); req_write_data_in = 64'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("drain_ready", EW'({req_ready_out, array_access_en_out}), '0);
    end
    req_valid_in = 1'b0;
    resp_ready_in = 1'b1;
    wait_drain();
    check_init(1'b0);
    send(1'b0, 5, 16'h0008, '0, 64'h0, w, a);
    send(1'b0, 1, 16'h0001, '0, 64'h0, w, a);
    send(1'b0, 2, 16'h0008, '0, 64'h0, w, a);
    wait_drain();

    // 6a: reset in the middle of the init sweep.
    init_start_in = 1'b1;
    align();
    init_start_in = 1'b0;
    w = 0;
    @(negedge clk_in);
    while (!(array_access_en_out && array_set_addr_out == SW'(30)) && w < 100) begin
      @(negedge clk_in);
      w++;
    end
    check("reach_set30", EW'(array_set_addr_out), 64'd30);
    reset_n_in = 1'b0;
    #1;
    check_all_zero("rst_mid_init");
    align();
    reset_n_in = 1'b1;
    check_init(1'b1);

    // 6b: reset with three responses queued.
    resp_ready_in = 1'b0;
    for (int s = 0; s < 3; s++) send(1'b0, s, 16'h0001, '0, 64'h0, w, a);
    align();
    @(negedge clk_in);
    check("queued_valid", EW'(resp_valid_out), 64'd1);
    reset_n_in = 1'b0;
    #1;
    check_all_zero("rst_mid_run");
    exp_q.delete();
    align();
    align();
    reset_n_in = 1'b1;
    check_init(1'b1);
    check("fifo_empty_after_rst", EW'(resp_valid_out), '0);
    resp_ready_in = 1'b1;
    send(1'b0, 5, 16'h0008, '0, 64'h0, w, a);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
